reg_write_scheduler: RTL and testbench

Shares the register bank's single write port between the pipeline writeback stage and a long-latency unit (multiply/divide) whose results arrive out of order with the pipeline. It also keeps a scoreboard of registers awaiting a long-latency result, and stalls decode on RAW/WAW hazards against them. It sits between writeback, the long-latency unit, decode hazard logic and the register bank write inputs.

---
 rtl/reg_write_scheduler.sv | 109 ++++++++++
 tb/tb_reg_write_scheduler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_scheduler.sv
// Shares the register-bank write port between pipeline writeback and a long-latency unit,
// and tracks registers awaiting long-latency results so that decode can stall on hazards.
module reg_write_scheduler #(
  parameter int FIFO_DEPTH  = 2,
  parameter int MAX_PENDING = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [4:0]  issue_dest,
  output logic        issue_ready,
  input  logic [4:0]  dec_rs_id,
  input  logic [4:0]  dec_rt_id,
  input  logic [4:0]  dec_dest_id,
  input  logic        dec_dest_write,
  output logic        hazard_stall,
  input  logic        wb_write,
  input  logic [4:0]  wb_dest,
  input  logic [31:0] wb_value,
  input  logic        lu_valid,
  input  logic [4:0]  lu_dest,
  input  logic [31:0] lu_value,
  output logic        lu_ready,
  output logic        rf_write,
  output logic [4:0]  rf_dest,
  output logic [31:0] rf_value,
  output logic        protocol_error
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [4:0]       fifo_dest  [FIFO_DEPTH];
  logic [31:0]      fifo_value [FIFO_DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic [31:0]      pending, pending_next;
  logic [3:0]       outstanding;

  logic       empty, drain, push, accept, dec_out;
  logic [4:0] head_dest;

  assign empty     = (count == '0);
  assign head_dest = fifo_dest[head];
  assign drain     = ~wb_write & ~empty;
  assign lu_ready  = (count < CNT_W'(FIFO_DEPTH)) | drain;
  assign push      = lu_valid & lu_ready;
  assign issue_ready = (outstanding < 4'(MAX_PENDING)) &
                       ~((issue_dest != 5'd0) & pending[issue_dest]);
  assign accept    = issue_valid & issue_ready;
  assign dec_out   = drain & (outstanding != 4'd0);

  // pending[0] is never set, so register-0 IDs cannot stall.
  assign hazard_stall = pending[dec_rs_id] | pending[dec_rt_id] |
                        (dec_dest_write & pending[dec_dest_id]);

  always_comb begin
    rf_write = wb_write;
    rf_dest  = wb_dest;
    rf_value = wb_value;
    if (drain) begin
      rf_write = (head_dest != 5'd0);
      rf_dest  = head_dest;
      rf_value = fifo_value[head];
    end
  end

  // Clear on drain first so that a same-cycle issue to that register wins.
  always_comb begin
    pending_next = pending;
    if (drain) pending_next[head_dest] = 1'b0;
    if (accept && issue_dest != 5'd0) pending_next[issue_dest] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_dest[tail]  <= lu_dest;
      fifo_value[tail] <= lu_value;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      pending        <= '0;
      outstanding    <= '0;
      protocol_error <= 1'b0;
    end else begin
      if (push)  tail <= tail + PTR_W'(1);
      if (drain) head <= head + PTR_W'(1);
      if (push && !drain)      count <= count + CNT_W'(1);
      else if (!push && drain) count <= count - CNT_W'(1);

      if (accept && !dec_out)      outstanding <= outstanding + 4'd1;
      else if (!accept && dec_out) outstanding <= outstanding - 4'd1;

      pending <= pending_next;

      if ((push && lu_dest != 5'd0 && !pending[lu_dest]) ||
          (wb_write && wb_dest != 5'd0 && pending[wb_dest]) ||
          (push && outstanding == 4'd0))
        protocol_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_write_scheduler.sv
// Directed plus randomized checks of reg_write_scheduler against a queue-based reference model.
module tb_reg_write_scheduler;

  localparam int FD = 2;
  localparam int MP = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        issue_valid, dec_dest_write, wb_write, lu_valid;
  logic [4:0]  issue_dest, dec_rs_id, dec_rt_id, dec_dest_id, wb_dest, lu_dest;
  logic [31:0] wb_value, lu_value;
  logic        issue_ready, hazard_stall, lu_ready, rf_write, protocol_error;
  logic [4:0]  rf_dest;
  logic [31:0] rf_value;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] value;
  } ent_t;

  ent_t q[$];
  bit   pend[32];
  int   outst;
  bit   err;

  reg_write_scheduler #(.FIFO_DEPTH(FD), .MAX_PENDING(MP)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_ready(issue_ready),
    .dec_rs_id(dec_rs_id), .dec_rt_id(dec_rt_id), .dec_dest_id(dec_dest_id),
    .dec_dest_write(dec_dest_write), .hazard_stall(hazard_stall),
    .wb_write(wb_write), .wb_dest(wb_dest), .wb_value(wb_value),
    .lu_valid(lu_valid), .lu_dest(lu_dest), .lu_value(lu_value), .lu_ready(lu_ready),
    .rf_write(rf_write), .rf_dest(rf_dest), .rf_value(rf_value),
    .protocol_error(protocol_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    foreach (pend[i]) pend[i] = 1'b0;
    outst = 0;
    err = 1'b0;
  endtask

  function automatic bit m_drain();
    return !wb_write && q.size() > 0;
  endfunction

  function automatic bit m_issue_ready();
    return outst < MP && !(issue_dest != 0 && pend[issue_dest]);
  endfunction

  task automatic check_all();
    bit d = m_drain();
    chk("issue_ready", issue_ready, m_issue_ready());
    chk("lu_ready", lu_ready, q.size() < FD || d);
    chk("hazard_stall", hazard_stall,
        pend[dec_rs_id] || pend[dec_rt_id] || (dec_dest_write && pend[dec_dest_id]));
    chk("protocol_error", protocol_error, err);
    if (wb_write) begin
      chk("rf_write", rf_write, 1);
      chk("rf_dest_wb", rf_dest, wb_dest);
      chk("rf_value_wb", rf_value, wb_value);
    end else if (d) begin
      chk("rf_write", rf_write, q[0].dest != 0);
      chk("rf_dest_lu", rf_dest, q[0].dest);
      chk("rf_value_lu", rf_value, q[0].value);
    end else begin
      chk("rf_write", rf_write, 0);
    end
  endtask

  task automatic model_update();
    bit d = m_drain();
    bit p = lu_valid && (q.size() < FD || d);
    bit a = issue_valid && m_issue_ready();
    ent_t e;
    if (p && lu_dest != 0 && !pend[lu_dest]) err = 1'b1;
    if (wb_write && wb_dest != 0 && pend[wb_dest]) err = 1'b1;
    if (p && outst == 0) err = 1'b1;
    if (d) begin
      e = q.pop_front();
      pend[e.dest] = 1'b0;
      if (outst > 0) outst--;
    end
    if (p) begin
      e.dest = lu_dest;
      e.value = lu_value;
      q.push_back(e);
    end
    if (a) begin
      outst++;
      if (issue_dest != 0) pend[issue_dest] = 1'b1;
    end
  endtask

  task automatic idle();
    issue_valid = 0; issue_dest = 0;
    dec_rs_id = 0; dec_rt_id = 0; dec_dest_id = 0; dec_dest_write = 0;
    wb_write = 0; wb_dest = 0; wb_value = 0;
    lu_valid = 0; lu_dest = 0; lu_value = 0;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic tick();
    check_all();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  // Asserts reset away from any clock edge and checks its immediate effect.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    chk("rst_protocol_error", protocol_error, 0);
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_lu_ready", lu_ready, 1);
    chk("rst_hazard_stall", hazard_stall, 0);
    chk("rst_rf_write", rf_write, wb_write);
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle();
  endtask

  initial begin
    idle();
    do_reset();

    // Issue 5, result later, no writeback contention.
    issue_valid = 1; issue_dest = 5; step();
    idle(); dec_rs_id = 5; settle(); chk("s1_stall_after_issue", hazard_stall, 1); tick();
    dec_rs_id = 5; step();
    lu_valid = 1; lu_dest = 5; lu_value = 32'hDEADBEEF; step();
    idle(); dec_rs_id = 5; settle();
    chk("s1_rf_write", rf_write, 1);
    chk("s1_rf_dest", rf_dest, 5);
    chk("s1_rf_value", rf_value, 32'hDEADBEEF);
    tick();
    dec_rs_id = 5; settle(); chk("s1_stall_cleared", hazard_stall, 0); tick();

    // Writeback held for 3 cycles starves the buffered result.
    do_reset();
    issue_valid = 1; issue_dest = 5; step();
    idle(); step();
    for (int i = 0; i < 3; i++) begin
      idle();
      wb_write = 1; wb_dest = 7; wb_value = 32'h11;
      if (i == 0) begin lu_valid = 1; lu_dest = 5; lu_value = 32'hDEADBEEF; end
      settle();
      chk("s2_rf_dest_wb", rf_dest, 7);
      chk("s2_rf_value_wb", rf_value, 32'h11);
      tick();
    end
    idle(); settle();
    chk("s2_rf_dest_lu", rf_dest, 5);
    chk("s2_rf_value_lu", rf_value, 32'hDEADBEEF);
    tick();
    step();
    chk("s2_no_error", protocol_error, 0);

    // FIFO full under held writeback, then in-order drain.
    do_reset();
    for (int d = 1; d <= 3; d++) begin
      issue_valid = 1; issue_dest = 5'(d); step();
    end
    idle();
    wb_write = 1; wb_dest = 20; wb_value = 32'hAAAA;
    lu_valid = 1; lu_dest = 1; lu_value = 32'h101; step();
    lu_dest = 2; lu_value = 32'h202; step();
    lu_dest = 3; lu_value = 32'h303; settle(); chk("s3_full_not_ready", lu_ready, 0); tick();
    wb_write = 0; settle();
    chk("s3_ready_on_drain", lu_ready, 1);
    chk("s3_drain1", rf_dest, 1);
    tick();
    lu_valid = 0; settle(); chk("s3_drain2", rf_dest, 2); tick();
    settle();
    chk("s3_drain3", rf_dest, 3);
    chk("s3_drain3_value", rf_value, 32'h303);
    tick();
    chk("s3_no_error", protocol_error, 0);

    // Outstanding limit and refusal of a pending re-issue.
    do_reset();
    for (int d = 10; d <= 13; d++) begin
      issue_valid = 1; issue_dest = 5'(d); settle(); chk("s4_issue_ok", issue_ready, 1); tick();
    end
    issue_dest = 14; settle(); chk("s4_fifth_refused", issue_ready, 0); tick();
    idle(); lu_valid = 1; lu_dest = 10; lu_value = 32'hA; step();
    idle(); step();
    issue_valid = 1; issue_dest = 11; settle(); chk("s4_reissue_refused", issue_ready, 0); tick();

    // Issue to the register whose result drains in the same cycle.
    do_reset();
    issue_valid = 1; issue_dest = 4; step();
    idle(); lu_valid = 1; lu_dest = 9; lu_value = 32'h99; step();
    idle(); issue_valid = 1; issue_dest = 9; settle();
    chk("s5_issue_ok", issue_ready, 1);
    chk("s5_drain9", rf_dest, 9);
    tick();
    idle(); dec_rs_id = 9; settle(); chk("s5_still_pending", hazard_stall, 1); tick();
    for (int d = 20; d <= 22; d++) begin
      issue_valid = 1; issue_dest = 5'(d); settle(); chk("s5_issue_fill", issue_ready, 1); tick();
    end
    issue_dest = 23; settle(); chk("s5_outstanding_full", issue_ready, 0); tick();

    // Sticky protocol error cleared only by asynchronous reset.
    do_reset();
    issue_valid = 1; issue_dest = 6; step();
    idle(); wb_write = 1; wb_dest = 6; wb_value = 32'h66; step();
    idle(); step();
    chk("s6_error_set", protocol_error, 1);
    step(); step();
    chk("s6_error_sticky", protocol_error, 1);
    do_reset();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      issue_valid    = ($urandom_range(0, 2) == 0);
      issue_dest     = 5'($urandom_range(0, 7));
      dec_rs_id      = 5'($urandom_range(0, 7));
      dec_rt_id      = 5'($urandom_range(0, 7));
      dec_dest_id    = 5'($urandom_range(0, 7));
      dec_dest_write = 1'($urandom_range(0, 1));
      wb_write       = ($urandom_range(0, 3) == 0);
      wb_dest        = 5'($urandom_range(0, 15));
      wb_value       = $urandom;
      lu_valid       = ($urandom_range(0, 2) == 0);
      lu_dest        = 5'($urandom_range(0, 7));
      lu_value       = $urandom;
      step();
      if (n % 100 == 99) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
